// File: rtl/aes_round_if.sv
// Bus bundle between the AES round controller, its state registers and the round logic.
// The abort input exists only when AES_ROUND_ABORT_EN is defined.
interface aes_round_if;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned IDX_W   = 4;

  logic               start;
  logic [BLOCK_W-1:0] in_block;
  logic [BLOCK_W-1:0] key0;
  logic [BLOCK_W-1:0] round_data;
  logic [BLOCK_W-1:0] curr_state;
  logic               out_ready;
  logic               in_ready;
  logic               state_we;
  logic [BLOCK_W-1:0] new_state;
  logic [IDX_W-1:0]   round_idx;
  logic               last_round;
  logic               out_valid;
  logic [BLOCK_W-1:0] out_block;
`ifdef AES_ROUND_ABORT_EN
  logic               abort;
`endif

  modport slave (
    input  start, in_block, key0, round_data, curr_state, out_ready,
    output in_ready, state_we, new_state, round_idx, last_round, out_valid, out_block
`ifdef AES_ROUND_ABORT_EN
    , input abort
`endif
  );

  modport master (
    output start, in_block, key0, round_data, curr_state, out_ready,
    input  in_ready, state_we, new_state, round_idx, last_round, out_valid, out_block
`ifdef AES_ROUND_ABORT_EN
    , output abort
`endif
  );
endinterface

// File: rtl/aes_round_ctrl.sv
// Sequencer for an iterative AES encryption core: key whitening, NUM_ROUNDS round writes, output handshake.
// Optional feature macro: AES_ROUND_ABORT_EN (adds an abort input that cancels a block in flight).
module aes_round_ctrl #(
  parameter int unsigned NUM_ROUNDS = 10
) (
  input logic       clk,
  input logic       resetn,
  aes_round_if.slave bus
);
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned IDX_W   = 4;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   round_cnt;
  logic [IDX_W-1:0]   round_cnt_nxt;
  logic               is_last;
  logic               abort_c;

`ifdef AES_ROUND_ABORT_EN
  assign abort_c = bus.abort;
`else
  assign abort_c = 1'b0;
`endif

  assign is_last = (round_cnt == IDX_W'(NUM_ROUNDS));

  // State and round counter registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      round_cnt <= '0;
    end else begin
      state     <= state_nxt;
      round_cnt <= round_cnt_nxt;
    end
  end

  // Next-state; counter parks at NUM_ROUNDS+1 in DONE and clears on return to IDLE
  always_comb begin
    state_nxt     = state;
    round_cnt_nxt = round_cnt;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt     = ROUND;
          round_cnt_nxt = IDX_W'(1);
        end
      end
      ROUND: begin
        if (abort_c) begin
          state_nxt     = IDLE;
          round_cnt_nxt = '0;
        end else begin
          round_cnt_nxt = round_cnt + IDX_W'(1);
          if (is_last) state_nxt = DONE;
        end
      end
      DONE: begin
        if (abort_c || bus.out_ready) begin
          state_nxt     = IDLE;
          round_cnt_nxt = '0;
        end
      end
      default: begin
        state_nxt     = IDLE;
        round_cnt_nxt = '0;
      end
    endcase
  end

  // Outputs; the start write is gated by resetn so nothing is written while reset is held
  always_comb begin
    bus.in_ready   = (state == IDLE);
    bus.state_we   = 1'b0;
    bus.new_state  = '0;
    bus.out_valid  = 1'b0;
    bus.round_idx  = round_cnt;
    bus.last_round = (state == ROUND) && is_last;
    bus.out_block  = bus.curr_state;
    unique case (state)
      IDLE: begin
        if (bus.start && resetn) begin
          bus.state_we  = 1'b1;
          bus.new_state = bus.in_block ^ bus.key0;
        end
      end
      ROUND: begin
        if (!abort_c) begin
          bus.state_we  = 1'b1;
          bus.new_state = BLOCK_W'(bus.round_data);
        end
      end
      DONE: begin
        bus.out_valid = 1'b1;
      end
      default: begin
        bus.state_we = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl with a behavioural state register and AES-128 round/key model.
module tb_aes_round_ctrl;
  localparam int NR = 10;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;

  logic clk;
  logic resetn;
  int   errors = 0;
  int   checks = 0;

  aes_round_if bus();

  aes_round_ctrl #(.NUM_ROUNDS(NR)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- AES-128 reference model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] inv;
    sq = b; inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [31:0] w0, w1, w2, w3, t;
    logic [7:0]  rc;
    {w0, w1, w2, w3} = key;
    rc = 8'h01;
    for (int j = 1; j <= n; j++) begin
      t  = sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h000000};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rc = gmul(rc, 8'h02);
    end
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) b[i] = sbox(st[127-8*i -: 8]);
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) t[r+4*c] = b[r+4*((c+r)%4)];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = t[i];
    return res ^ rk;
  endfunction

  // External round logic and state registers around the controller
  assign bus.round_data = aes_round(bus.curr_state, round_key(bus.key0, int'(bus.round_idx)),
                                    bus.last_round);
  always @(posedge clk) if (bus.state_we) bus.curr_state <= bus.new_state;

  // ---------------- scenarios ----------------
  task automatic test_reset();
    resetn = 1'b0;
    bus.start = 1'b0; bus.out_ready = 1'b0;
    bus.in_block = '0; bus.key0 = '0;
`ifdef AES_ROUND_ABORT_EN
    bus.abort = 1'b0;
`endif
    #2;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset in_ready: got %b exp 1", bus.in_ready); end
    checks++; if (bus.state_we !== 1'b0) begin errors++; $display("FAIL reset state_we: got %b exp 0", bus.state_we); end
    checks++; if (bus.new_state !== 128'h0) begin errors++; $display("FAIL reset new_state: got %h exp 0", bus.new_state); end
    checks++; if (bus.round_idx !== 4'd0) begin errors++; $display("FAIL reset round_idx: got %0d exp 0", bus.round_idx); end
    checks++; if (bus.last_round !== 1'b0) begin errors++; $display("FAIL reset last_round: got %b exp 0", bus.last_round); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b exp 0", bus.out_valid); end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Encrypt one block from IDLE; hold>0 stalls DONE with start pulses, overlap raises start with out_ready.
  task automatic run_block(input logic [127:0] blk, input logic [127:0] key, input logic [127:0] exp,
                           input int hold, input bit overlap, input string tag);
    bus.in_block = blk; bus.key0 = key; bus.start = 1'b1; bus.out_ready = 1'b0;
    #1;
    checks++; if (bus.state_we !== 1'b1) begin errors++; $display("FAIL %s whiten_we: got %b exp 1", tag, bus.state_we); end
    checks++; if (bus.new_state !== (blk ^ key)) begin errors++; $display("FAIL %s whiten_data: got %h exp %h", tag, bus.new_state, blk ^ key); end
    checks++; if (bus.in_ready !== 1'b1 || bus.round_idx !== 4'd0) begin errors++; $display("FAIL %s idle_flags: got rdy=%b idx=%0d exp rdy=1 idx=0", tag, bus.in_ready, bus.round_idx); end
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      #1;
      checks++; if (bus.state_we !== 1'b1 || bus.round_idx !== 4'(k)) begin errors++; $display("FAIL %s round_we_idx: got we=%b idx=%0d exp we=1 idx=%0d", tag, bus.state_we, bus.round_idx, k); end
      checks++; if (bus.last_round !== (k == NR)) begin errors++; $display("FAIL %s last_round: got %b exp %b at idx %0d", tag, bus.last_round, (k == NR), k); end
      checks++; if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL %s round_flags: got rdy=%b vld=%b exp 0 0", tag, bus.in_ready, bus.out_valid); end
      checks++; if (bus.new_state !== bus.round_data) begin errors++; $display("FAIL %s round_data: got %h exp %h", tag, bus.new_state, bus.round_data); end
      @(negedge clk);
    end
    #1;
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL %s done_valid: got %b exp 1", tag, bus.out_valid); end
    checks++; if (bus.out_block !== exp) begin errors++; $display("FAIL %s out_block: got %h exp %h", tag, bus.out_block, exp); end
    checks++; if (bus.state_we !== 1'b0 || bus.new_state !== 128'h0) begin errors++; $display("FAIL %s done_we: got we=%b data=%h exp 0 0", tag, bus.state_we, bus.new_state); end
    checks++; if (bus.round_idx !== 4'(NR + 1) || bus.last_round !== 1'b0) begin errors++; $display("FAIL %s done_idx: got idx=%0d last=%b exp %0d 0", tag, bus.round_idx, bus.last_round, NR + 1); end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      bus.start = (h == 1 || h == 3);
      bus.in_block = ~blk;
      #1;
      checks++; if (bus.out_valid !== 1'b1 || bus.out_block !== exp) begin errors++; $display("FAIL %s stall_hold: got vld=%b blk=%h exp 1 %h", tag, bus.out_valid, bus.out_block, exp); end
      checks++; if (bus.state_we !== 1'b0 || bus.in_ready !== 1'b0) begin errors++; $display("FAIL %s stall_start: got we=%b rdy=%b exp 0 0", tag, bus.state_we, bus.in_ready); end
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.start = overlap;
    bus.in_block = blk;
    #1;
    if (overlap) begin
      checks++; if (bus.state_we !== 1'b0) begin errors++; $display("FAIL %s overlap_we: got %b exp 0", tag, bus.state_we); end
    end
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.start = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.round_idx !== 4'd0) begin errors++; $display("FAIL %s back_idle: got rdy=%b vld=%b idx=%0d exp 1 0 0", tag, bus.in_ready, bus.out_valid, bus.round_idx); end
    @(negedge clk);
  endtask

  task automatic test_fips_c1();
    run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0, "c1");
  endtask

  task automatic test_done_stall();
    run_block(B_PT, B_KEY, B_CT, 5, 1'b0, "stall");
  endtask

  task automatic test_back_to_back();
    run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b1, "b2b_a");
    run_block(B_PT, B_KEY, B_CT, 0, 1'b0, "b2b_b");
  endtask

  task automatic test_reset_mid();
    bit seen = 1'b0;
    bus.in_block = B_PT; bus.key0 = B_KEY; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus.round_idx === 4'd5) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL rst_mid reach_idx5: got idx=%0d exp 5", bus.round_idx); end
    resetn = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.state_we !== 1'b0 || bus.new_state !== 128'h0) begin errors++; $display("FAIL rst_mid async_ctl: got rdy=%b we=%b data=%h exp 1 0 0", bus.in_ready, bus.state_we, bus.new_state); end
    checks++; if (bus.round_idx !== 4'd0 || bus.last_round !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid async_idx: got idx=%0d last=%b vld=%b exp 0 0 0", bus.round_idx, bus.last_round, bus.out_valid); end
    @(negedge clk);
    resetn = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid !== 1'b0 || bus.state_we !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL rst_mid quiet: got activity=1 exp 0"); end
    @(negedge clk);
    run_block(C1_PT, C1_KEY, C1_CT, 0, 1'b0, "after_rst");
  endtask

`ifdef AES_ROUND_ABORT_EN
  task automatic test_abort();
    bit seen = 1'b0;
    bus.in_block = C1_PT; bus.key0 = C1_KEY; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      #1;
      if (bus.round_idx === 4'd3) seen = 1'b1;
      else @(negedge clk);
    end
    checks++; if (!seen) begin errors++; $display("FAIL abort reach_idx3: got idx=%0d exp 3", bus.round_idx); end
    bus.abort = 1'b1;
    #1;
    checks++; if (bus.state_we !== 1'b0 || bus.new_state !== 128'h0) begin errors++; $display("FAIL abort kill_we: got we=%b data=%h exp 0 0", bus.state_we, bus.new_state); end
    @(negedge clk);
    bus.abort = 1'b0;
    #1;
    checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.round_idx !== 4'd0) begin errors++; $display("FAIL abort idle: got rdy=%b vld=%b idx=%0d exp 1 0 0", bus.in_ready, bus.out_valid, bus.round_idx); end
    seen = 1'b0;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk); #1;
      if (bus.out_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL abort no_valid: got out_valid=1 exp 0"); end
    @(negedge clk);
    run_block(B_PT, B_KEY, B_CT, 0, 1'b0, "after_abort");
  endtask
`endif

  initial begin
    test_reset();
    test_fips_c1();
    test_done_stall();
    test_back_to_back();
    test_reset_mid();
`ifdef AES_ROUND_ABORT_EN
    test_abort();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
